// File: rtl/apb_timer_if.sv
// APB bus bundle between the core's APB master and the apb_timer responder.
// Signal names follow the APB protocol; clk/rst_n stay outside the interface.
interface apb_timer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_timer.sv
// APB responder: 32-bit down-counting timer with level interrupt and configurable wait states.
// Optional prescaler register at offset 0x10 is built when APB_TIMER_PRESCALE_EN is defined.
module apb_timer #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    apb_timer_if.slave  bus,
    output logic        irq
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic        sel, setup, access, pready, wr;
    logic        wr_ctrl, wr_load, wr_status;
    logic [2:0]  idx;
    logic [3:0]  wait_cnt;
    logic [31:0] prdata, rdata;
    logic [2:0]  ctrl;
    logic [31:0] load, count;
    logic        expired;
    logic        strobe, tick, expire;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, bus.PADDR[1:0]};

    assign idx    = bus.PADDR[4:2];
    assign sel    = bus.PSEL && (bus.PADDR[31:5] == BASE_ADDR[31:5]);
    assign setup  = sel && !bus.PENABLE;
    assign access = sel && bus.PENABLE;
    // Gated by rst_n so a transfer caught mid-ACCESS by reset never completes.
    assign pready = rst_n && access && (wait_cnt == WS);
    assign wr     = pready && bus.PWRITE;

    assign wr_ctrl   = wr && (idx == 3'd0);
    assign wr_load   = wr && (idx == 3'd1);
    assign wr_status = wr && (idx == 3'd3);

    assign bus.PREADY = pready;
    assign bus.PRDATA = prdata;
    assign irq        = expired && ctrl[2];

`ifdef APB_TIMER_PRESCALE_EN
    logic        wr_presc;
    logic [15:0] prescale, presc_cnt;

    assign wr_presc = wr && (idx == 3'd4);
    assign strobe   = (presc_cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale  <= '0;
            presc_cnt <= '0;
        end else begin
            if (wr_presc)
                prescale <= bus.PWDATA[15:0];
            if (!ctrl[0] || wr_presc || wr_load || strobe)
                presc_cnt <= '0;
            else
                presc_cnt <= presc_cnt + 16'd1;
        end
    end
`else
    assign strobe = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0: rdata = {29'd0, ctrl};
            3'd1: rdata = load;
            3'd2: rdata = count;
            3'd3: rdata = {31'd0, expired};
`ifdef APB_TIMER_PRESCALE_EN
            3'd4: rdata = {16'd0, prescale};
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            prdata   <= '0;
        end else if (setup) begin
            wait_cnt <= '0;
            if (!bus.PWRITE)
                prdata <= rdata;
        end else if (access && !pready) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // A LOAD write or a CTRL write that clears EN suppresses this edge's tick.
    assign tick   = ctrl[0] && strobe && !wr_load && !(wr_ctrl && !bus.PWDATA[0]);
    assign expire = tick && (count == 32'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (wr_load) begin
                load  <= bus.PWDATA;
                count <= bus.PWDATA;
            end else if (tick) begin
                if (count != 32'd0)
                    count <= count - 32'd1;
                else if (ctrl[1])
                    count <= load;
            end

            if (wr_ctrl)
                ctrl <= bus.PWDATA[2:0];
            else if (expire && !ctrl[1])
                ctrl[0] <= 1'b0;

            if (expire)
                expired <= 1'b1;
            else if (wr_status && bus.PWDATA[0])
                expired <= 1'b0;
        end
    end
endmodule
